// File: rtl/bp_pred_unit.sv
// Branch direction predictor: a PC-indexed table of 2-bit saturating counters
// plus an in-order queue of in-flight predictions that is retired at resolve.
module bp_pred_unit #(
    parameter int unsigned IDX_BITS = 4,
    parameter int unsigned Q_DEPTH  = 4,
    parameter int unsigned PC_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lookup_valid,
    input  logic [PC_W-1:0]            lookup_pc,
    output logic                       lookup_ready,
    output logic                       pred_taken,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic                       flush,
    output logic                       mispredict,
    output logic                       resolve_err,
    output logic [$clog2(Q_DEPTH):0]   q_count,
    output logic [15:0]                miss_count
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned PTR_W   = $clog2(Q_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned MISS_W  = 16;

    localparam logic [1:0]        CTR_RESET = 2'b01;
    localparam logic [MISS_W-1:0] MISS_MAX  = {MISS_W{1'b1}};

    // Counter state and queue storage
    logic [1:0]          tbl    [ENTRIES];
    logic [IDX_BITS-1:0] q_idx  [Q_DEPTH];
    logic                q_pred [Q_DEPTH];

    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;

    logic [IDX_BITS-1:0] lookup_idx;
    logic [IDX_BITS-1:0] head_idx;
    logic                head_pred;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                miss_now;
    logic                unused_pc_bits;

    // Saturating 2-bit counter step toward the observed outcome
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        r = c;
        if (taken) begin
            if (c != 2'b11) r = c + 2'd1;
        end else begin
            if (c != 2'b00) r = c - 2'd1;
        end
        return r;
    endfunction

    always_comb begin
        lookup_idx     = lookup_pc[IDX_BITS-1:0];
        unused_pc_bits = ^lookup_pc[PC_W-1:IDX_BITS];
        pred_taken     = tbl[lookup_idx][1];
        full           = (q_count == CNT_W'(Q_DEPTH));
        empty          = (q_count == CNT_W'(0));
        lookup_ready   = !full && !flush;
        push           = lookup_valid && lookup_ready;
        pop            = resolve_valid && !empty;
        head_idx       = q_idx[head];
        head_pred      = q_pred[head];
        miss_now       = pop && (head_pred != resolve_taken);
    end

    // Table entries: pred_taken reads the pre-update value in the resolve cycle
    for (genvar g = 0; g < ENTRIES; g++) begin : g_tbl
        always_ff @(posedge clk) begin
            if (rst) begin
                tbl[g] <= CTR_RESET;
            end else if (pop && (head_idx == IDX_BITS'(g))) begin
                tbl[g] <= ctr_step(tbl[g], resolve_taken);
            end
        end
    end

    // Queue payload needs no reset: occupancy is tracked by q_count
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[tail]  <= lookup_idx;
            q_pred[tail] <= pred_taken;
        end
    end

    // Pointers and occupancy; flush wins over any push/pop bookkeeping
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head    <= '0;
            tail    <= '0;
            q_count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   q_count <= q_count + CNT_W'(1);
                2'b01:   q_count <= q_count - CNT_W'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // Resolve result pulses and saturating miss statistic
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict  <= 1'b0;
            resolve_err <= 1'b0;
            miss_count  <= '0;
        end else begin
            mispredict  <= miss_now;
            resolve_err <= resolve_valid && empty;
            if (miss_now && (miss_count != MISS_MAX)) begin
                miss_count <= miss_count + MISS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bp_pred_unit.sv
// Randomized scoreboard bench for bp_pred_unit against a queue/array reference model.
module tb_bp_pred_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        lookup_valid;
    logic [15:0] lookup_pc;
    logic        lookup_ready;
    logic        pred_taken;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        flush;
    logic        mispredict;
    logic        resolve_err;
    logic [2:0]  q_count;
    logic [15:0] miss_count;

    bp_pred_unit #(.IDX_BITS(4), .Q_DEPTH(DEPTH), .PC_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .lookup_valid  (lookup_valid),
        .lookup_pc     (lookup_pc),
        .lookup_ready  (lookup_ready),
        .pred_taken    (pred_taken),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .flush         (flush),
        .mispredict    (mispredict),
        .resolve_err   (resolve_err),
        .q_count       (q_count),
        .miss_count    (miss_count)
    );

    typedef struct {
        int idx;
        bit pred;
    } ent_t;

    typedef struct {
        bit mis;
        bit err;
        int miss;
        int qc;
    } exp_t;

    // Reference model: counters as plain ints 0..3, in-flight queue, statistic
    int   ctr [16];
    ent_t inflight [$];
    int   miss;
    exp_t exp_q [$];

    int n_chk;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle of stimulus, check combinational outputs, advance the model
    task automatic step(input bit r, input bit lv, input logic [15:0] pc,
                        input bit rv, input bit rt, input bit fl);
        int   idx;
        bit   pred;
        bit   rdy;
        exp_t e;
        ent_t h;
        rst           = r;
        lookup_valid  = lv;
        lookup_pc     = pc;
        resolve_valid = rv;
        resolve_taken = rt;
        flush         = fl;
        #1;
        idx  = int'(pc) % 16;
        pred = (ctr[idx] >= 2);
        rdy  = (inflight.size() < DEPTH) && !fl;
        chk("pred_taken", int'(pred_taken), int'(pred));
        chk("lookup_ready", int'(lookup_ready), int'(rdy));
        e = '{mis: 1'b0, err: 1'b0, miss: 0, qc: 0};
        if (r) begin
            foreach (ctr[i]) ctr[i] = 1;
            inflight.delete();
            miss = 0;
        end else begin
            if (rv) begin
                if (inflight.size() == 0) begin
                    e.err = 1'b1;
                end else begin
                    h = inflight.pop_front();
                    e.mis = (h.pred != rt);
                    if (rt) ctr[h.idx] = (ctr[h.idx] == 3) ? 3 : ctr[h.idx] + 1;
                    else    ctr[h.idx] = (ctr[h.idx] == 0) ? 0 : ctr[h.idx] - 1;
                    if (e.mis && miss < 65535) miss++;
                end
            end
            if (fl) inflight.delete();
            else if (lv && rdy) inflight.push_back('{idx: idx, pred: pred});
        end
        e.miss = miss;
        e.qc   = inflight.size();
        exp_q.push_back(e);
    endtask

    // Monitor: compare registered outputs after every active edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mispredict", int'(mispredict), int'(e.mis));
            chk("resolve_err", int'(resolve_err), int'(e.err));
            chk("miss_count", int'(miss_count), e.miss);
            chk("q_count", int'(q_count), e.qc);
        end
    end

    initial begin
        bit rt;
        n_chk  = 0;
        n_pass = 0;
        miss   = 0;
        foreach (ctr[i]) ctr[i] = 1;
        rst = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;

        @(negedge clk); step(1, 0, 16'h0, 0, 0, 0);
        @(negedge clk); step(0, 0, 16'h0, 0, 0, 0);

        // Directed start: pc 3 trained taken, then a fill past full, then empty resolve
        @(negedge clk); step(0, 1, 16'h0003, 0, 0, 0);
        @(negedge clk); step(0, 1, 16'h0003, 0, 0, 0);
        @(negedge clk); step(0, 0, 16'h0003, 1, 1, 0);
        @(negedge clk); step(0, 0, 16'h0003, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); step(0, 1, 16'h0010 + 16'(i), 0, 0, 0);
        end
        @(negedge clk); step(0, 1, 16'h0014, 1, 1, 0);
        @(negedge clk); step(0, 1, 16'h0014, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); step(0, 0, 16'h0000, 1, 0, 0);
        end
        @(negedge clk); step(0, 1, 16'h0021, 0, 0, 0);
        @(negedge clk); step(0, 1, 16'h0022, 0, 0, 0);
        @(negedge clk); step(0, 1, 16'h0023, 1, 1, 1);

        // Random mix including flushes, empty resolves and occasional reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 6),
                 16'($urandom),
                 ($urandom_range(0, 9) < 4),
                 1'($urandom),
                 ($urandom_range(0, 29) == 0));
        end

        // Drive miss_count into saturation by always resolving against the head prediction
        for (int i = 0; i < 80000 && miss < 65535 + 8; i++) begin
            @(negedge clk);
            rt = (inflight.size() > 0) ? !inflight[0].pred : 1'b0;
            step(0, 1, 16'h0005, (inflight.size() > 0), rt, 0);
            if (miss == 65535) break;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rt = (inflight.size() > 0) ? !inflight[0].pred : 1'b0;
            step(0, 1, 16'h0005, (inflight.size() > 0), rt, 0);
        end

        // Reset with everything asserted, then sweep all indices
        @(negedge clk); step(0, 1, 16'h0007, 0, 0, 0);
        @(negedge clk); step(1, 1, 16'h0008, 1, 1, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); step(0, 0, 16'(i), 0, 0, 0);
        end
        @(negedge clk); step(0, 0, 16'h0, 1, 0, 0);

        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
